// File: rtl/cook_pkg.sv
// cook_pkg: shared state encoding and time constants for the cook timer
package cook_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, READY = 3'd1, COOKING = 3'd2, PAUSED = 3'd3, DONE = 3'd4} state_t;
  localparam int MAX_S_DEF = 5999;
  localparam int ADD_S = 30;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every CLK_DIV enabled cycles, cleared while disabled
module tick_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV + 1);
  logic [W-1:0] cnt;
  assign tick = enable && (cnt == W'(CLK_DIV - 1));
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: cook time countdown FSM driving magnetron latch set/reset pulses
// Optional COOK_ADD30_EN: start while cooking adds 30 s, start in IDLE quick-starts 30 s
module cook_timer_ctrl
  import cook_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int TIME_W  = 13,
  parameter int MAX_S   = MAX_S_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic              start,
  input  logic              stop_clr,
  input  logic              door_closed,
  output logic              set_mag,
  output logic              reset_mag,
  output logic [TIME_W-1:0] remaining,
  output logic              done,
  output logic [2:0]        state_o
);
  state_t state;
  logic tick, door_q;
  logic [TIME_W-1:0] cap, added;
`ifdef COOK_ADD30_EN
  logic [TIME_W:0] sum;
`endif
  assign state_o = state;
  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
    .clk(clk),
    .rst(rst),
    .enable(state == COOKING),
    .tick(tick)
  );
  always_comb begin
    cap = (time_in > TIME_W'(MAX_S)) ? TIME_W'(MAX_S) : time_in;
`ifdef COOK_ADD30_EN
    sum = {1'b0, remaining} + (TIME_W+1)'(ADD_S);
    added = start ? ((sum > (TIME_W+1)'(MAX_S)) ? TIME_W'(MAX_S) : sum[TIME_W-1:0]) : remaining;
`else
    added = remaining;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      set_mag   <= 1'b0;
      reset_mag <= 1'b1;
      done      <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      set_mag   <= 1'b0;
      reset_mag <= 1'b0;
      door_q    <= door_closed;
      case (state)
        IDLE: begin
          if (load && time_in != '0) begin
            state     <= READY;
            remaining <= cap;
          end
`ifdef COOK_ADD30_EN
          else if (start && door_closed && remaining == '0) begin
            state     <= COOKING;
            remaining <= TIME_W'(ADD_S);
            set_mag   <= 1'b1;
          end
`endif
        end
        READY: begin
          if (stop_clr) begin
            state     <= IDLE;
            remaining <= '0;
          end else if (start && door_closed) begin
            state   <= COOKING;
            set_mag <= 1'b1;
          end else if (load) begin
            remaining <= cap;
            if (cap == '0) state <= IDLE;
          end
        end
        COOKING: begin
          if (!door_closed || stop_clr) begin
            state     <= PAUSED;
            reset_mag <= 1'b1;
          end else if (tick && added <= TIME_W'(1)) begin
            state     <= DONE;
            remaining <= '0;
            reset_mag <= 1'b1;
            done      <= 1'b1;
          end else if (tick) remaining <= added - 1'b1;
          else remaining <= added;
        end
        PAUSED: begin
          if (stop_clr) begin
            state     <= IDLE;
            remaining <= '0;
          end else if (start && door_closed) begin
            state   <= COOKING;
            set_mag <= 1'b1;
          end
        end
        DONE: begin
          if (stop_clr || (door_q && !door_closed)) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb_cook_timer_ctrl: directed vectors with hand-computed expectations, CLK_DIV=4
module tb_cook_timer_ctrl;
  logic clk = 1'b0, rst, load, start, stop_clr, door_closed;
  logic [12:0] time_in, remaining;
  logic set_mag, reset_mag, done;
  logic [2:0] state_o;
  int vecs = 0, errs = 0;

  cook_timer_ctrl #(.CLK_DIV(4), .TIME_W(13), .MAX_S(5999)) dut (
    .clk(clk), .rst(rst), .load(load), .time_in(time_in), .start(start),
    .stop_clr(stop_clr), .door_closed(door_closed), .set_mag(set_mag),
    .reset_mag(reset_mag), .remaining(remaining), .done(done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input int t);
    time_in = 13'(t); load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_clr = 1'b1; step(); stop_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop_clr = 1'b0; door_closed = 1'b1; time_in = '0;
    step(2);
    chk("rst_reset_mag", reset_mag, 1);
    chk("rst_state", state_o, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_set_mag", set_mag, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; step();
    chk("rst_release_reset_mag", reset_mag, 0);

    // full countdown from 3 s
    pulse_load(3);
    chk("load3_state", state_o, 1);
    chk("load3_rem", remaining, 3);
    pulse_start();
    chk("start_set_mag", set_mag, 1);
    chk("start_state", state_o, 2);
    step(3);
    chk("pre_tick_rem", remaining, 3);
    chk("set_mag_one_cycle", set_mag, 0);
    step();
    chk("tick1_rem", remaining, 2);
    step(4);
    chk("tick2_rem", remaining, 1);
    step(4);
    chk("tick3_rem", remaining, 0);
    chk("done_state", state_o, 4);
    chk("done_reset_mag", reset_mag, 1);
    chk("done_level", done, 1);
    step();
    chk("done_reset_mag_drop", reset_mag, 0);
    chk("done_hold", done, 1);
    door_closed = 1'b0; step();
    chk("door_open_from_done", state_o, 0);
    chk("done_cleared", done, 0);
    door_closed = 1'b1; step();

    // pause by door, resume
    pulse_load(5);
    pulse_start();
    door_closed = 1'b0; step();
    chk("pause_state", state_o, 3);
    chk("pause_reset_mag", reset_mag, 1);
    chk("pause_rem", remaining, 5);
    step(6);
    chk("paused_no_pulse", reset_mag, 0);
    chk("paused_rem_hold", remaining, 5);
    door_closed = 1'b1;
    pulse_start();
    chk("resume_set_mag", set_mag, 1);
    chk("resume_state", state_o, 2);
    step(3);
    chk("resume_pre_tick", remaining, 5);
    step();
    chk("resume_tick", remaining, 4);
    pulse_stop();
    chk("stop_pause_state", state_o, 3);
    chk("stop_pause_reset_mag", reset_mag, 1);
    pulse_stop();
    chk("stop_clear_state", state_o, 0);
    chk("stop_clear_rem", remaining, 0);

    // start with door open in READY is ignored
    pulse_load(7);
    door_closed = 1'b0;
    pulse_start();
    chk("ready_open_state", state_o, 1);
    chk("ready_open_set_mag", set_mag, 0);
    door_closed = 1'b1;
    pulse_stop();
    chk("ready_clr_state", state_o, 0);
    chk("ready_clr_rem", remaining, 0);

    // load saturation
    pulse_load(8000);
    chk("sat_rem", remaining, 5999);
    chk("sat_state", state_o, 1);
    pulse_load(0);
    chk("reload_zero_state", state_o, 0);

    // start during cook
    pulse_load(10);
    pulse_start();
    pulse_start();
    chk("add_set_mag", set_mag, 0);
    chk("add_state", state_o, 2);
`ifdef COOK_ADD30_EN
    chk("add_rem", remaining, 40);
`else
    chk("add_rem", remaining, 10);
`endif
    pulse_stop(); pulse_stop();
    pulse_load(5990);
    pulse_start();
    pulse_start();
`ifdef COOK_ADD30_EN
    chk("add_sat_rem", remaining, 5999);
`else
    chk("add_sat_rem", remaining, 5990);
`endif
    pulse_stop(); pulse_stop();

    // quick start from IDLE
    pulse_start();
`ifdef COOK_ADD30_EN
    chk("quick_state", state_o, 2);
    chk("quick_rem", remaining, 30);
    chk("quick_set_mag", set_mag, 1);
`else
    chk("quick_state", state_o, 0);
    chk("quick_rem", remaining, 0);
    chk("quick_set_mag", set_mag, 0);
`endif
    pulse_stop(); pulse_stop();

    // reset mid-cook
    pulse_load(4);
    pulse_start();
    step(2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_state", state_o, 0);
    chk("midrst_reset_mag", reset_mag, 1);
    chk("midrst_rem", remaining, 0);
    step();
    chk("midrst_release", reset_mag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
